// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake bundle between PC/fetch logic (master) and
// the instruction memory (slave).
interface imem_fetch_port_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            flush;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_instr;
  logic [31:0]     rsp_addr;
  logic [1:0]      rsp_fault;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_port.sv
// Registered-read instruction memory with valid/ready fetch port, address fault
// detection and sticky fault capture. Optional load port: IMEM_LOAD_PORT_EN.
module imem_fetch_port #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 1024,
  parameter logic [31:0]     BASE_ADDR = 32'h0000_0000,
  parameter string           INIT_FILE = "memfile.hex",
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef IMEM_LOAD_PORT_EN
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_widx,
  input  logic [XLEN-1:0]          ld_data,
`endif
  imem_fetch_port_if.slave         bus,
  output logic                     fault_sticky,
  output logic [31:0]              fault_addr
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] FaultNone       = 2'b00;
  localparam logic [1:0] FaultMisaligned = 2'b01;
  localparam logic [1:0] FaultRange      = 2'b10;

  logic [XLEN-1:0] mem [DEPTH];

  logic            rsp_valid_q;
  logic [XLEN-1:0] rd_q;
  logic [31:0]     rsp_addr_q;
  logic [1:0]      rsp_fault_q;
  logic            fault_sticky_q;
  logic [31:0]     fault_addr_q;

  logic [29:0]     off_word;
  logic [AW-1:0]   widx;
  logic [1:0]      fault_code;
  logic            ld_busy;
  logic            accept;

`ifdef IMEM_LOAD_PORT_EN
  assign ld_busy = ld_we;

  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_widx] <= ld_data;
  end
`else
  assign ld_busy = 1'b0;
`endif

  always_comb begin
    off_word = 30'((bus.req_addr - BASE_ADDR) >> 2);
    widx     = off_word[AW-1:0];
    // Misalignment wins; below-base addresses wrap off_word, so test them explicitly.
    if (bus.req_addr[1:0] != 2'b00) begin
      fault_code = FaultMisaligned;
    end else if ((bus.req_addr < BASE_ADDR) || ({2'b00, off_word} >= 32'(DEPTH))) begin
      fault_code = FaultRange;
    end else begin
      fault_code = FaultNone;
    end
  end

  assign bus.req_ready = !rst && !bus.flush && !ld_busy && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Synchronous read port kept separate from the control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (accept) begin
      rd_q <= mem[widx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_addr_q     <= '0;
      rsp_fault_q    <= FaultNone;
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= '0;
    end else if (bus.flush) begin
      rsp_valid_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_addr_q  <= bus.req_addr;
      rsp_fault_q <= fault_code;
      if ((fault_code != FaultNone) && !fault_sticky_q) begin
        fault_sticky_q <= 1'b1;
        fault_addr_q   <= bus.req_addr;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = (rsp_fault_q != FaultNone) ? NOP_INSTR : rd_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign fault_sticky  = fault_sticky_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: two instances (base 0 and base 0x8000_0000),
// expected responses queued at issue and checked by per-instance monitors.
module tb_imem_fetch_port;

  localparam logic [31:0] W0  = 32'h0062_E233;
  localparam logic [31:0] W1  = 32'h00B6_2423;
  localparam logic [31:0] W2  = 32'h0083_2383;
  localparam logic [31:0] W3  = 32'hFFC4_A303;
  localparam logic [31:0] WT  = 32'h1234_5678;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        fs0, fs1;
  logic [31:0] fa0, fa1;

`ifdef IMEM_LOAD_PORT_EN
  logic        ld_we   = 1'b0;
  logic [9:0]  ld_widx = '0;
  logic [31:0] ld_data = '0;
`endif

  imem_fetch_port_if #(.XLEN(32)) bus0 ();
  imem_fetch_port_if #(.XLEN(32)) bus1 ();

  imem_fetch_port #(
    .XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0000_0000), .INIT_FILE(""), .NOP_INSTR(NOP)
  ) dut0 (
    .clk(clk),
    .rst(rst),
`ifdef IMEM_LOAD_PORT_EN
    .ld_we(ld_we),
    .ld_widx(ld_widx),
    .ld_data(ld_data),
`endif
    .bus(bus0),
    .fault_sticky(fs0),
    .fault_addr(fa0)
  );

  imem_fetch_port #(
    .XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .INIT_FILE(""), .NOP_INSTR(NOP)
  ) dut1 (
    .clk(clk),
    .rst(rst),
`ifdef IMEM_LOAD_PORT_EN
    .ld_we(ld_we),
    .ld_widx(ld_widx),
    .ld_data(ld_data),
`endif
    .bus(bus1),
    .fault_sticky(fs1),
    .fault_addr(fa1)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus0.rsp_valid && bus0.rsp_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected: got response addr 0x%08h expected none", bus0.rsp_addr);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_instr", bus0.rsp_instr, e0.instr);
        chk("dut0_addr", bus0.rsp_addr, e0.addr);
        chk("dut0_fault", 32'(bus0.rsp_fault), 32'(e0.fault));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.rsp_valid && bus1.rsp_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected: got response addr 0x%08h expected none", bus1.rsp_addr);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_instr", bus1.rsp_instr, e1.instr);
        chk("dut1_addr", bus1.rsp_addr, e1.addr);
        chk("dut1_fault", 32'(bus1.rsp_fault), 32'(e1.fault));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [5];
    logic [9:0]  idxs  [5];
    logic [31:0] addrs [4];
    words = '{W0, W1, W2, W3, WT};
    idxs  = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd1023};
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};

    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.flush = 1'b0; bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.flush = 1'b0; bus1.rsp_ready = 1'b1;

`ifdef IMEM_LOAD_PORT_EN
    // Preload through the load port while reset is held.
    for (int i = 0; i < 5; i++) begin
      ld_we = 1'b1; ld_widx = idxs[i]; ld_data = words[i];
      tick();
    end
    ld_we = 1'b0;
`else
    for (int i = 0; i < 5; i++) begin
      dut0.mem[idxs[i]] = words[i];
      dut1.mem[idxs[i]] = words[i];
    end
    tick();
`endif
    tick();

    // Reset state
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'h0);
    chk("rst_rsp_instr", bus0.rsp_instr, 32'h0);
    chk("rst_rsp_addr", bus0.rsp_addr, 32'h0);
    chk("rst_rsp_fault", 32'(bus0.rsp_fault), 32'h0);
    chk("rst_fault_sticky", 32'(fs0), 32'h0);
    chk("rst_fault_addr", fa0, 32'h0);
    chk("rst_req_ready", 32'(bus0.req_ready), 32'h0);
    rst = 1'b0;
    tick();

    // Back-to-back fetches
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.req_addr = addrs[i];
      q0.push_back('{instr: words[i], addr: addrs[i], fault: 2'b00});
      #1;
      chk("b2b_req_ready", 32'(bus0.req_ready), 32'h1);
      tick();
      chk("b2b_rsp_valid", 32'(bus0.rsp_valid), 32'h1);
    end
    bus0.req_valid = 1'b0;
    tick();
    chk("b2b_rsp_valid_drop", 32'(bus0.rsp_valid), 32'h0);

    // Stall with a pending request
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h4;
    q0.push_back('{instr: W1, addr: 32'h4, fault: 2'b00});
    tick();
    bus0.rsp_ready = 1'b0; bus0.req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req_ready", 32'(bus0.req_ready), 32'h0);
      chk("stall_rsp_valid", 32'(bus0.rsp_valid), 32'h1);
      chk("stall_rsp_instr", bus0.rsp_instr, W1);
      tick();
    end
    bus0.rsp_ready = 1'b1;
    q0.push_back('{instr: W2, addr: 32'h8, fault: 2'b00});
    #1;
    chk("unstall_req_ready", 32'(bus0.req_ready), 32'h1);
    tick();
    bus0.req_valid = 1'b0;
    #1;
    chk("unstall_rsp_instr", bus0.rsp_instr, W2);
    tick();

    // Faults: misaligned, top word in range, just past the top
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h6;
    q0.push_back('{instr: NOP, addr: 32'h6, fault: 2'b01});
    tick();
    chk("mis_fault_sticky", 32'(fs0), 32'h1);
    chk("mis_fault_addr", fa0, 32'h6);
    bus0.req_addr = 32'hFFC;
    q0.push_back('{instr: WT, addr: 32'hFFC, fault: 2'b00});
    tick();
    bus0.req_addr = 32'h1000;
    q0.push_back('{instr: NOP, addr: 32'h1000, fault: 2'b10});
    tick();
    bus0.req_valid = 1'b0;
    tick();
    chk("oor_fault_sticky", 32'(fs0), 32'h1);
    chk("oor_fault_addr_kept", fa0, 32'h6);

    // Non-zero base address
    bus1.req_valid = 1'b1; bus1.req_addr = 32'h8000_0000;
    q1.push_back('{instr: W0, addr: 32'h8000_0000, fault: 2'b00});
    tick();
    bus1.req_addr = 32'h7FFF_FFFC;
    q1.push_back('{instr: NOP, addr: 32'h7FFF_FFFC, fault: 2'b10});
    tick();
    bus1.req_addr = 32'h8000_0FFC;
    q1.push_back('{instr: WT, addr: 32'h8000_0FFC, fault: 2'b00});
    tick();
    bus1.req_addr = 32'h8000_1000;
    q1.push_back('{instr: NOP, addr: 32'h8000_1000, fault: 2'b10});
    tick();
    bus1.req_valid = 1'b0;
    tick();
    chk("base_fault_sticky", 32'(fs1), 32'h1);
    chk("base_fault_addr", fa1, 32'h7FFF_FFFC);

    // Flush drops the held response and blocks the request on that edge
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
    q0.push_back('{instr: W0, addr: 32'h0, fault: 2'b00});
    tick();
    bus0.rsp_ready = 1'b0; bus0.flush = 1'b1; bus0.req_addr = 32'h4;
    #1;
    chk("flush_req_ready", 32'(bus0.req_ready), 32'h0);
    tick();
    chk("flush_rsp_valid", 32'(bus0.rsp_valid), 32'h0);
    q0.delete();
    bus0.flush = 1'b0;

    // Reset in the middle of a stall
    tick();
    bus0.req_valid = 1'b0;
    chk("rst_stall_rsp_valid", 32'(bus0.rsp_valid), 32'h1);
    chk("rst_stall_rsp_instr", bus0.rsp_instr, W1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_rsp_valid", 32'(bus0.rsp_valid), 32'h0);
    chk("rst2_rsp_instr", bus0.rsp_instr, 32'h0);
    chk("rst2_rsp_addr", bus0.rsp_addr, 32'h0);
    chk("rst2_rsp_fault", 32'(bus0.rsp_fault), 32'h0);
    chk("rst2_fault_sticky", 32'(fs0), 32'h0);
    chk("rst2_fault_addr", fa0, 32'h0);
    q0.delete();
    rst = 1'b0;
    bus0.rsp_ready = 1'b1;
    tick();

`ifdef IMEM_LOAD_PORT_EN
    // Load-port write blocks fetches and is visible to the next fetch
    ld_we = 1'b1; ld_widx = 10'd2; ld_data = 32'hDEAD_BEEF;
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
    #1;
    chk("ld_req_ready", 32'(bus0.req_ready), 32'h0);
    tick();
    ld_we = 1'b0; bus0.req_addr = 32'h8;
    q0.push_back('{instr: 32'hDEAD_BEEF, addr: 32'h8, fault: 2'b00});
    tick();
    bus0.req_valid = 1'b0;
    tick();
`endif

    tick();
    tick();
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
